addsub_chunked: RTL and testbench



---
 rtl/addsub_chunked.sv | 84 ++++++++
 tb/tb_addsub_chunked.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
// addsub_chunked: signed a+b / a-b on WIDTH bits, CHUNK bits per cycle, LSB chunk first,
// with overflow/carry flags, optional saturation and valid/ready handshakes.
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovp,
  output logic             ovn,
  output logic             carry
);
  localparam int N = WIDTH / CHUNK;
  localparam int KW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic up, sat_r, carry_int, last, ovp_nx, ovn_nx;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] a_r, be_r, r_nx;
  logic [CHUNK:0] sum;
  int base;
  assign in_ready = up && state == IDLE;
  assign out_valid = state == DONE;
  assign last = k == KW'(N - 1);
  assign base = int'(k) * CHUNK;
  // subtraction is a + ~b + 1, the +1 arriving as the initial carry_int
  assign sum = {1'b0, a_r[base +: CHUNK]} + {1'b0, be_r[base +: CHUNK]} + {{CHUNK{1'b0}}, carry_int};
  always_comb begin
    r_nx = result;
    r_nx[base +: CHUNK] = sum[CHUNK-1:0];
    ovp_nx = ~a_r[WIDTH-1] & ~be_r[WIDTH-1] & r_nx[WIDTH-1];
    ovn_nx = a_r[WIDTH-1] & be_r[WIDTH-1] & ~r_nx[WIDTH-1];
    state_nx = state == IDLE ? (in_valid && in_ready ? BUSY : IDLE) :
               state == BUSY ? (last ? DONE : BUSY) :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      up <= 1'b0;
    end else begin
      state <= state_nx;
      up <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      ovp <= 1'b0;
      ovn <= 1'b0;
      carry <= 1'b0;
      k <= '0;
      carry_int <= 1'b0;
      a_r <= '0;
      be_r <= '0;
      sat_r <= 1'b0;
    end else if (in_valid && in_ready) begin
      a_r <= a;
      be_r <= sub ? ~b : b;
      sat_r <= sat;
      carry_int <= sub;
      k <= '0;
    end else if (state == BUSY) begin
      carry_int <= sum[CHUNK];
      k <= k + KW'(1);
      result <= last && sat_r && ovp_nx ? {1'b0, {(WIDTH-1){1'b1}}} :
                last && sat_r && ovn_nx ? {1'b1, {(WIDTH-1){1'b0}}} : r_nx;
      if (last) begin
        ovp <= ovp_nx;
        ovn <= ovn_nx;
        carry <= sum[CHUNK];
      end
    end
  end
endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked: directed and random operations against a scoreboard of expected results.
module tb_addsub_chunked #(
  parameter int CHUNK = 4
);
  localparam int W = 16;
  localparam int N = W / CHUNK;
  localparam longint MAXP = (64'sd1 <<< (W - 1)) - 1;
  typedef struct {
    logic [W-1:0] a, b, res;
    logic sub, sat, ovp, ovn, carry;
  } op_t;
  logic clk, rst_n, in_valid, in_ready, sub, sat, out_valid, out_ready, ovp, ovn, carry;
  logic [W-1:0] a, b, result;
  op_t sb[$];
  int checks = 0, errors = 0;

  addsub_chunked #(.WIDTH(W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovp(ovp), .ovn(ovn), .carry(carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic op_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic t);
    op_t m;
    longint v;
    logic [W:0] ua;
    v = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
    ua = {1'b0, x} + {1'b0, y};
    m.a = x;
    m.b = y;
    m.sub = s;
    m.sat = t;
    m.ovp = v > MAXP;
    m.ovn = v < -MAXP - 1;
    m.res = t && m.ovp ? {1'b0, {(W-1){1'b1}}} : t && m.ovn ? {1'b1, {(W-1){1'b0}}} : W'(v);
    m.carry = s ? x >= y : ua[W];
    return m;
  endfunction

  task automatic run_op(input op_t o, input int hold);
    int n;
    op_t e;
    sb.push_back(o);
    a = o.a;
    b = o.b;
    sub = o.sub;
    sat = o.sat;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
    n = 0;
    do begin
      if (n > 0 || !out_valid) begin
        tick();
        n++;
      end
    end while (!out_valid && n < 200);
    chk("latency", n, N);
    e = sb.pop_front();
    chk("result", result, e.res);
    chk("ovp", ovp, e.ovp);
    chk("ovn", ovn, e.ovn);
    chk("carry", carry, e.carry);
    for (int i = 0; i < hold; i++) begin
      in_valid = i == 1;
      a = ~o.a;
      b = 16'h1;
      tick();
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, e.res);
      chk("hold_flags", {ovp, ovn, carry}, {e.ovp, e.ovn, e.carry});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_rise", in_ready, 1);
  endtask

  initial begin
    op_t dir[9];
    op_t o;
    bit seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    sat = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {ovp, ovn, carry}, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("release_in_ready", in_ready, 1);

    dir[0] = '{a:16'h1234, b:16'h0FFF, res:16'h2233, sub:0, sat:0, ovp:0, ovn:0, carry:0};
    dir[1] = '{a:16'h0005, b:16'h0007, res:16'hFFFE, sub:1, sat:0, ovp:0, ovn:0, carry:0};
    dir[2] = '{a:16'h0007, b:16'h0005, res:16'h0002, sub:1, sat:0, ovp:0, ovn:0, carry:1};
    dir[3] = '{a:16'h0000, b:16'h8000, res:16'h8000, sub:1, sat:0, ovp:1, ovn:0, carry:0};
    dir[4] = '{a:16'h0000, b:16'h8000, res:16'h7FFF, sub:1, sat:1, ovp:1, ovn:0, carry:0};
    dir[5] = '{a:16'h8000, b:16'hFFFF, res:16'h8000, sub:0, sat:1, ovp:0, ovn:1, carry:1};
    dir[6] = '{a:16'h8000, b:16'hFFFF, res:16'h7FFF, sub:0, sat:0, ovp:0, ovn:1, carry:1};
    dir[7] = '{a:16'h8000, b:16'h8000, res:16'h0000, sub:1, sat:1, ovp:0, ovn:0, carry:1};
    dir[8] = '{a:16'h7FFF, b:16'h0001, res:16'h7FFF, sub:0, sat:1, ovp:1, ovn:0, carry:0};
    foreach (dir[i]) run_op(dir[i], 0);

    run_op(dir[0], 5);
    seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("no_capture_during_done", seen, 0);

    for (int i = 0; i < 8; i++) begin
      o = model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      run_op(o, 0);
    end

    a = 16'h1234;
    b = 16'h0FFF;
    sub = 1'b0;
    sat = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("midrst_release_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      seen |= out_valid;
    end
    chk("midrst_no_result", seen, 0);
    chk("scoreboard_empty", sb.size(), 0);
    run_op(dir[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
